// File: rtl/apb_master_if.sv
// Command, response and APB bus signals for apb_master, grouped for port use.
// The master modport is the DUT view; the slave modport is the environment view.
interface apb_master_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic            i_cmd_valid;
  logic            o_cmd_ready;
  logic [AW-1:0]   i_cmd_addr;
  logic            i_cmd_write;
  logic [DW-1:0]   i_cmd_wdata;
  logic [DW/8-1:0] i_cmd_strb;

  logic            o_rsp_valid;
  logic            i_rsp_ready;
  logic [DW-1:0]   o_rsp_rdata;
  logic            o_rsp_err;
  logic            o_rsp_timeout;

  logic [AW-1:0]   o_paddr;
  logic            o_pwrite;
  logic            o_psel;
  logic            o_penable;
  logic [DW-1:0]   o_pwdata;
  logic [DW/8-1:0] o_pstrb;
  logic [DW-1:0]   i_prdata;
  logic            i_pready;
  logic            i_pslverr;

  modport master (
    input  i_cmd_valid, i_cmd_addr, i_cmd_write, i_cmd_wdata, i_cmd_strb,
    input  i_rsp_ready, i_prdata, i_pready, i_pslverr,
    output o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
    output o_paddr, o_pwrite, o_psel, o_penable, o_pwdata, o_pstrb
  );

  modport slave (
    output i_cmd_valid, i_cmd_addr, i_cmd_write, i_cmd_wdata, i_cmd_strb,
    output i_rsp_ready, i_prdata, i_pready, i_pslverr,
    input  o_cmd_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err, o_rsp_timeout,
    input  o_paddr, o_pwrite, o_psel, o_penable, o_pwdata, o_pstrb
  );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB master: command in, one APB transfer, response out.
// All outputs are registered from the next state, so they change on the edge that enters a state.
module apb_master #(
  parameter int DW     = 32,
  parameter int AW     = 5,
  parameter int TO_CYC = 16
) (
  input logic          pclk,
  input logic          preset,
  apb_master_if.master bus
);

  localparam int            CW      = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
  localparam bit            TO_EN   = (TO_CYC > 0);
  localparam logic [CW-1:0] TO_LAST = (TO_CYC > 0) ? CW'(TO_CYC - 1) : '0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            expire_s;

  logic            cmd_ready_q, cmd_ready_d;
  logic            psel_q, psel_d;
  logic            penable_q, penable_d;
  logic            pwrite_q, pwrite_d;
  logic [AW-1:0]   paddr_q, paddr_d;
  logic [DW-1:0]   pwdata_q, pwdata_d;
  logic [DW/8-1:0] pstrb_q, pstrb_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_timeout_q, rsp_timeout_d;

  // Abort condition; a slave completing in the same cycle takes priority in the next-state logic.
  assign expire_s = TO_EN && (cnt_q == TO_LAST) && !bus.i_pready;

  // State, timeout counter and registered outputs.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Next-state logic and access-phase wait counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.i_cmd_valid && cmd_ready_q) begin
          state_d = SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (bus.i_pready || expire_s) begin
          state_d = RESP;
        end else begin
          state_d = ACCESS;
        end
      end
      RESP: begin
        if (bus.i_rsp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_q != ACCESS) begin
      cnt_d = '0;
    end else if (!bus.i_pready) begin
      cnt_d = cnt_q + CW'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Next values of the registered outputs; the APB request registers double as the command capture.
  always_comb begin
    cmd_ready_d   = (state_d == IDLE);
    psel_d        = (state_d == SETUP) || (state_d == ACCESS);
    penable_d     = (state_d == ACCESS);
    rsp_valid_d   = (state_d == RESP);
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    if ((state_q == IDLE) && (state_d == SETUP)) begin
      pwrite_d = bus.i_cmd_write;
      paddr_d  = bus.i_cmd_addr;
      if (bus.i_cmd_write) begin
        pwdata_d = bus.i_cmd_wdata;
        pstrb_d  = bus.i_cmd_strb;
      end else begin
        pwdata_d = '0;
        pstrb_d  = '0;
      end
    end else begin
      pwrite_d = pwrite_q;
      paddr_d  = paddr_q;
    end

    if ((state_q == ACCESS) && bus.i_pready) begin
      rsp_err_d     = bus.i_pslverr;
      rsp_timeout_d = 1'b0;
      rsp_rdata_d   = pwrite_q ? '0 : bus.i_prdata;
    end else if ((state_q == ACCESS) && expire_s) begin
      rsp_err_d     = 1'b1;
      rsp_timeout_d = 1'b1;
      rsp_rdata_d   = '0;
    end else begin
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;
    end
  end

  assign bus.o_cmd_ready   = cmd_ready_q;
  assign bus.o_psel        = psel_q;
  assign bus.o_penable     = penable_q;
  assign bus.o_pwrite      = pwrite_q;
  assign bus.o_paddr       = paddr_q;
  assign bus.o_pwdata      = pwdata_q;
  assign bus.o_pstrb       = pstrb_q;
  assign bus.o_rsp_valid   = rsp_valid_q;
  assign bus.o_rsp_rdata   = rsp_rdata_q;
  assign bus.o_rsp_err     = rsp_err_q;
  assign bus.o_rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: inputs change and outputs are checked on the falling edge.
module tb_apb_master;

  logic pclk;
  logic preset;
  int   total;
  int   passed;

  apb_master_if #(.DW(32), .AW(5)) bus ();

  apb_master #(.DW(32), .AW(5), .TO_CYC(16)) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus.master)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic tick;
    @(negedge pclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    preset = 1'b1;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_addr  = 5'h00;
    bus.i_cmd_write = 1'b0;
    bus.i_cmd_wdata = 32'h0;
    bus.i_cmd_strb  = 4'h0;
    bus.i_rsp_ready = 1'b1;
    bus.i_prdata    = 32'h0;
    bus.i_pready    = 1'b0;
    bus.i_pslverr   = 1'b0;

    // Reset state
    tick; tick;
    chk("rst_psel", bus.o_psel, 32'h0);
    chk("rst_penable", bus.o_penable, 32'h0);
    chk("rst_cmd_ready", bus.o_cmd_ready, 32'h0);
    chk("rst_rsp_valid", bus.o_rsp_valid, 32'h0);
    chk("rst_paddr", bus.o_paddr, 32'h0);
    chk("rst_rdata", bus.o_rsp_rdata, 32'h0);
    preset = 1'b0;
    tick;
    chk("rel_cmd_ready", bus.o_cmd_ready, 32'h1);

    // Write with two wait states; command inputs scrambled after capture
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_addr  = 5'h04;
    bus.i_cmd_write = 1'b1;
    bus.i_cmd_wdata = 32'hA5A5_0001;
    bus.i_cmd_strb  = 4'hF;
    bus.i_prdata    = 32'h1234_5678;
    tick;
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_addr  = 5'h1F;
    bus.i_cmd_write = 1'b0;
    bus.i_cmd_wdata = 32'h0;
    bus.i_cmd_strb  = 4'h0;
    chk("wr_setup_psel", bus.o_psel, 32'h1);
    chk("wr_setup_penable", bus.o_penable, 32'h0);
    chk("wr_setup_cmd_ready", bus.o_cmd_ready, 32'h0);
    chk("wr_setup_paddr", bus.o_paddr, 32'h04);
    chk("wr_setup_pwrite", bus.o_pwrite, 32'h1);
    chk("wr_setup_pwdata", bus.o_pwdata, 32'hA5A5_0001);
    chk("wr_setup_pstrb", bus.o_pstrb, 32'hF);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("wr_access_penable", bus.o_penable, 32'h1);
      chk("wr_access_psel", bus.o_psel, 32'h1);
      chk("wr_access_paddr", bus.o_paddr, 32'h04);
      chk("wr_access_pwdata", bus.o_pwdata, 32'hA5A5_0001);
      if (k == 2) bus.i_pready = 1'b1;
    end
    tick;
    bus.i_pready = 1'b0;
    chk("wr_rsp_valid", bus.o_rsp_valid, 32'h1);
    chk("wr_rsp_psel", bus.o_psel, 32'h0);
    chk("wr_rsp_penable", bus.o_penable, 32'h0);
    chk("wr_rsp_err", bus.o_rsp_err, 32'h0);
    chk("wr_rsp_timeout", bus.o_rsp_timeout, 32'h0);
    chk("wr_rsp_rdata", bus.o_rsp_rdata, 32'h0);
    tick;
    chk("wr_idle_rsp_valid", bus.o_rsp_valid, 32'h0);
    chk("wr_idle_cmd_ready", bus.o_cmd_ready, 32'h1);

    // Two back-to-back zero-wait reads: 4-cycle command period
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_addr  = 5'h0C;
    bus.i_cmd_write = 1'b0;
    bus.i_cmd_wdata = 32'hFFFF_FFFF;
    bus.i_cmd_strb  = 4'hF;
    bus.i_pready    = 1'b1;
    bus.i_prdata    = 32'hDEAD_BEEF;
    tick;
    chk("rd_setup_psel", bus.o_psel, 32'h1);
    chk("rd_setup_pstrb", bus.o_pstrb, 32'h0);
    chk("rd_setup_pwdata", bus.o_pwdata, 32'h0);
    chk("rd_setup_pwrite", bus.o_pwrite, 32'h0);
    chk("rd_setup_paddr", bus.o_paddr, 32'h0C);
    tick;
    chk("rd_access_penable", bus.o_penable, 32'h1);
    chk("rd_access_pstrb", bus.o_pstrb, 32'h0);
    tick;
    chk("rd_rsp_valid", bus.o_rsp_valid, 32'h1);
    chk("rd_rsp_rdata", bus.o_rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_rsp_err", bus.o_rsp_err, 32'h0);
    chk("rd_rsp_psel", bus.o_psel, 32'h0);
    tick;
    bus.i_prdata = 32'h0BAD_F00D;
    chk("rd_gap_psel", bus.o_psel, 32'h0);
    chk("rd_gap_cmd_ready", bus.o_cmd_ready, 32'h1);
    tick;
    bus.i_cmd_valid = 1'b0;
    chk("rd2_setup_psel", bus.o_psel, 32'h1);
    chk("rd2_setup_penable", bus.o_penable, 32'h0);
    tick;
    tick;
    chk("rd2_rsp_rdata", bus.o_rsp_rdata, 32'h0BAD_F00D);
    tick;

    // Write answered with a slave error
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_addr  = 5'h0C;
    bus.i_cmd_write = 1'b1;
    bus.i_cmd_wdata = 32'h0000_0011;
    bus.i_cmd_strb  = 4'h3;
    bus.i_pslverr   = 1'b1;
    tick;
    bus.i_cmd_valid = 1'b0;
    chk("err_setup_pstrb", bus.o_pstrb, 32'h3);
    tick;
    tick;
    bus.i_pslverr = 1'b0;
    chk("err_rsp_valid", bus.o_rsp_valid, 32'h1);
    chk("err_rsp_err", bus.o_rsp_err, 32'h1);
    chk("err_rsp_timeout", bus.o_rsp_timeout, 32'h0);
    chk("err_rsp_rdata", bus.o_rsp_rdata, 32'h0);
    tick;

    // Response back-pressure with a second command pending
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_addr  = 5'h08;
    bus.i_cmd_write = 1'b0;
    bus.i_prdata    = 32'hCAFE_0001;
    bus.i_rsp_ready = 1'b0;
    tick;
    bus.i_cmd_addr = 5'h10;
    tick;
    chk("bp_access_paddr", bus.o_paddr, 32'h08);
    tick;
    bus.i_prdata = 32'h0000_0099;
    chk("bp_rsp_rdata", bus.o_rsp_rdata, 32'hCAFE_0001);
    for (int k = 0; k < 5; k++) begin
      tick;
      chk("bp_hold_valid", bus.o_rsp_valid, 32'h1);
      chk("bp_hold_rdata", bus.o_rsp_rdata, 32'hCAFE_0001);
      chk("bp_hold_cmd_ready", bus.o_cmd_ready, 32'h0);
      chk("bp_hold_psel", bus.o_psel, 32'h0);
      if (k == 4) bus.i_rsp_ready = 1'b1;
    end
    tick;
    chk("bp_idle_rsp_valid", bus.o_rsp_valid, 32'h0);
    chk("bp_idle_cmd_ready", bus.o_cmd_ready, 32'h1);
    chk("bp_idle_psel", bus.o_psel, 32'h0);
    tick;
    bus.i_cmd_valid = 1'b0;
    chk("bp2_setup_psel", bus.o_psel, 32'h1);
    chk("bp2_setup_paddr", bus.o_paddr, 32'h10);
    tick;
    tick;
    chk("bp2_rsp_rdata", bus.o_rsp_rdata, 32'h0000_0099);
    tick;

    // Timeout: slave never ready, abort after 16 access cycles
    bus.i_pready    = 1'b0;
    bus.i_prdata    = 32'h0000_0055;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_addr  = 5'h14;
    bus.i_cmd_write = 1'b0;
    tick;
    bus.i_cmd_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick;
      chk("to_access_penable", bus.o_penable, 32'h1);
    end
    tick;
    chk("to_rsp_psel", bus.o_psel, 32'h0);
    chk("to_rsp_penable", bus.o_penable, 32'h0);
    chk("to_rsp_valid", bus.o_rsp_valid, 32'h1);
    chk("to_rsp_err", bus.o_rsp_err, 32'h1);
    chk("to_rsp_timeout", bus.o_rsp_timeout, 32'h1);
    chk("to_rsp_rdata", bus.o_rsp_rdata, 32'h0);
    tick;

    // Ready in the 16th access cycle: normal completion wins
    bus.i_prdata    = 32'h0000_0077;
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_addr  = 5'h18;
    tick;
    bus.i_cmd_valid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      tick;
      chk("late_access_penable", bus.o_penable, 32'h1);
      if (k == 15) bus.i_pready = 1'b1;
    end
    tick;
    bus.i_pready = 1'b0;
    chk("late_rsp_valid", bus.o_rsp_valid, 32'h1);
    chk("late_rsp_err", bus.o_rsp_err, 32'h0);
    chk("late_rsp_timeout", bus.o_rsp_timeout, 32'h0);
    chk("late_rsp_rdata", bus.o_rsp_rdata, 32'h0000_0077);
    tick;

    // Reset in the second access cycle
    bus.i_cmd_valid = 1'b1;
    bus.i_cmd_addr  = 5'h1C;
    bus.i_cmd_write = 1'b1;
    bus.i_cmd_wdata = 32'h0000_00AA;
    tick;
    bus.i_cmd_valid = 1'b0;
    tick;
    tick;
    chk("mid_access_penable", bus.o_penable, 32'h1);
    preset       = 1'b1;
    bus.i_pready = 1'b1;
    tick;
    preset = 1'b0;
    chk("mid_rst_psel", bus.o_psel, 32'h0);
    chk("mid_rst_penable", bus.o_penable, 32'h0);
    chk("mid_rst_rsp_valid", bus.o_rsp_valid, 32'h0);
    chk("mid_rst_cmd_ready", bus.o_cmd_ready, 32'h0);
    tick;
    chk("mid_rel_cmd_ready", bus.o_cmd_ready, 32'h1);
    chk("mid_rel_rsp_valid", bus.o_rsp_valid, 32'h0);
    tick;
    chk("mid_idle_rsp_valid", bus.o_rsp_valid, 32'h0);
    chk("mid_idle_psel", bus.o_psel, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter DW, default 32, APB data width; legal values 8, 16, 32.
REQ-002 Parameter AW, default 5, APB address width; maximum 32.
REQ-003 Parameter TO_CYC, default 16, access-phase timeout in cycles; 0 disables the timeout.
REQ-004 pclk  in  1  single clock; all logic is on the rising edge; reset is synchronous and active-high.
REQ-005 preset  in  1  synchronous, active-high reset.
REQ-006 i_cmd_valid  in  1 / o_cmd_ready  out  1  command handshake.
REQ-007 i_cmd_addr  in  AW / i_cmd_write  in  1 / i_cmd_wdata  in  DW / i_cmd_strb  in  DW/8  command payload.
REQ-008 o_rsp_valid  out  1 / i_rsp_ready  in  1  response handshake.
REQ-009 o_rsp_rdata  out  DW / o_rsp_err  out  1 / o_rsp_timeout  out  1  response payload.
REQ-010 o_paddr  out  AW / o_pwrite  out  1 / o_psel  out  1 / o_penable  out  1 / o_pwdata  out  DW / o_pstrb  out  DW/8  APB request to slave.
REQ-011 i_prdata  in  DW / i_pready  in  1 / i_pslverr  in  1  APB completion from slave.

Function
REQ-012 State machine states: IDLE, SETUP, ACCESS, RESP; all outputs are registered.
REQ-013 IDLE: o_cmd_ready=1, o_psel=0, o_penable=0; on i_cmd_valid&&o_cmd_ready, capture the full payload and go to SETUP.
REQ-014 o_cmd_ready SHALL be 1 only in IDLE, so at most one transfer is outstanding.
REQ-015 SETUP, one cycle: o_psel=1, o_penable=0, o_paddr/o_pwrite/o_pwdata/o_pstrb = captured values; then go to ACCESS.
REQ-016 ACCESS: o_psel=1, o_penable=1, APB outputs stable; remain in ACCESS while i_pready=0.
REQ-017 ACCESS with i_pready=1: capture i_pslverr into o_rsp_err; capture i_prdata into o_rsp_rdata on reads, 0 on writes; set o_rsp_timeout=0; go to RESP with o_psel and o_penable low from the next cycle.
REQ-018 o_pstrb SHALL be forced to 0 on reads; o_pwdata is don't-care on reads and is driven 0.
REQ-019 Timeout counter: cleared on entry to ACCESS, incremented every ACCESS cycle with i_pready=0.
REQ-020 If TO_CYC>0 and the counter reaches TO_CYC-1 with i_pready=0: abort, deassert o_psel/o_penable, set o_rsp_err=1, o_rsp_timeout=1, o_rsp_rdata=0, go to RESP.
REQ-021 If i_pready=1 arrives in the same cycle as timeout expiry, normal completion wins (REQ-017).
REQ-022 RESP: o_rsp_valid=1 with payload stable until i_rsp_ready=1; then go to IDLE with o_rsp_valid=0 the next cycle.
REQ-023 Minimum transfer with zero-wait slave and i_rsp_ready=1: IDLE->SETUP->ACCESS->RESP->IDLE, one command per 4 cycles.
REQ-024 o_psel SHALL be low for at least one cycle between transfers; no back-to-back ACCESS->SETUP.
REQ-025 Changes on i_cmd_* after capture SHALL NOT affect the transfer in flight.

Reset
REQ-026 While preset=1 at a clock edge: state=IDLE; o_psel, o_penable, o_pwrite, o_rsp_valid, o_rsp_err, o_rsp_timeout = 0; o_paddr, o_pwdata, o_pstrb, o_rsp_rdata = 0; o_cmd_ready=0.
REQ-027 o_cmd_ready SHALL go to 1 on the first edge after preset deasserts.
REQ-028 Reset mid-transfer (SETUP/ACCESS/RESP) SHALL drop o_psel/o_penable/o_rsp_valid at that edge with no response issued.

Verification
REQ-029 Write addr 0x04, wdata 0xA5A5_0001, strb 0xF, slave pready after 2 wait cycles -> SETUP 1 cycle, ACCESS 3 cycles, rsp err=0 timeout=0 rdata=0.
REQ-030 Read addr 0x0C, slave returns 0xDEAD_BEEF with zero wait -> o_pstrb=0 during transfer, rsp rdata=0xDEAD_BEEF, 4-cycle command period.
REQ-031 Write addr 0x0C, slave returns pslverr=1 -> rsp err=1, timeout=0.
REQ-032 TO_CYC=16, slave never raises pready -> psel drops after 16 ACCESS cycles, rsp err=1 timeout=1 rdata=0; pready on cycle 16 instead -> normal completion.
REQ-033 rsp_ready held 0 for 5 cycles with a second command pending -> rsp_valid and payload stable, cmd_ready=0, psel=0 until the handshake.
REQ-034 preset asserted in the second ACCESS cycle -> psel/penable/rsp_valid 0 next edge, cmd_ready=1 one edge after release.
